// File: rtl/x86_prefix_decoder.sv
// x86_prefix_decoder: absorbs x86 prefix bytes and emits one registered opcode record per instruction
module x86_prefix_decoder #(
  parameter int                  IP_WIDTH  = 32,
  parameter int                  MAX_LEN   = 15,
  parameter bit                  EXT_FS_GS = 1'b1,
  parameter logic [IP_WIDTH-1:0] RESET_IP  = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                def_opsize,
  input  logic                def_adsize,
  input  logic                flush,
  input  logic [IP_WIDTH-1:0] flush_ip,
  input  logic                in_valid,
  input  logic [7:0]          in_byte,
  output logic                in_ready,
  output logic [IP_WIDTH-1:0] ip,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8:0]          out_opcode,
  output logic [2:0]          out_seg_id,
  output logic                out_seg_pre,
  output logic                out_opsize,
  output logic                out_adsize,
  output logic [1:0]          out_rep,
  output logic                out_lock,
  output logic [3:0]          out_len,
  output logic                out_fault,
  output logic [IP_WIDTH-1:0] out_ip_start,
  output logic [IP_WIDTH-1:0] out_ip_next
);
  typedef enum logic [1:0] {PREFIX, ESC, OUT} state_t;
  typedef struct packed {
    logic [8:0]          opcode;
    logic [2:0]          seg_id;
    logic                seg_pre;
    logic                opsize;
    logic                adsize;
    logic [1:0]          rep;
    logic                lock;
    logic [3:0]          len;
    logic                fault;
    logic [IP_WIDTH-1:0] ip_start;
    logic [IP_WIDTH-1:0] ip_next;
  } rec_t;
  state_t              state_q, state_d;
  rec_t                cur_q, cur_d, out_q, out_d;
  logic [IP_WIDTH-1:0] ip_q, ip_d;
  logic                dop_q, dop_d, dad_q, dad_d;
  logic                acc, is_seg, is_fsgs, is_esc, is_pfx, hit_max, term, restart;
  function automatic rec_t fresh(input logic [IP_WIDTH-1:0] start, input logic op, input logic ad);
    fresh = '0;
    fresh.seg_id = 3'd3;
    fresh.opsize = op;
    fresh.adsize = ad;
    fresh.ip_start = start;
  endfunction
  assign acc = in_valid & in_ready;
  always_comb begin
    is_seg = in_byte[7:5] == 3'b001 && in_byte[2:0] == 3'b110;
    is_fsgs = EXT_FS_GS && in_byte[7:1] == 7'b0110010;
    is_esc = in_byte == 8'h0f;
    is_pfx = is_seg | is_fsgs | is_esc | in_byte[7:1] == 7'b0110011 | in_byte == 8'hf0 | in_byte[7:1] == 7'b1111001;
    hit_max = cur_q.len + 4'd1 == 4'(MAX_LEN);
    term = state_q == ESC || !is_pfx || hit_max;
    restart = flush || (state_q == OUT && out_ready);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PREFIX;
      ip_q <= RESET_IP;
      cur_q <= fresh(RESET_IP, def_opsize, def_adsize);
      out_q <= '0;
      dop_q <= def_opsize;
      dad_q <= def_adsize;
    end else begin
      state_q <= state_d;
      ip_q <= ip_d;
      cur_q <= cur_d;
      out_q <= out_d;
      dop_q <= dop_d;
      dad_q <= dad_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (flush) state_d = PREFIX;
    else if (state_q == OUT) state_d = out_ready ? PREFIX : OUT;
    else if (acc) state_d = term ? OUT : is_esc ? ESC : PREFIX;
  end
  // prefixes set the non-default size against the size latched at instruction start
  always_comb begin
    cur_d = cur_q;
    out_d = out_q;
    dop_d = dop_q;
    dad_d = dad_q;
    ip_d = flush ? flush_ip : acc ? ip_q + IP_WIDTH'(1) : ip_q;
    if (restart) begin
      cur_d = fresh(flush ? flush_ip : ip_q, def_opsize, def_adsize);
      dop_d = def_opsize;
      dad_d = def_adsize;
    end else if (acc) begin
      cur_d.len = cur_q.len + 4'd1;
      if (state_q == PREFIX) begin
        if (is_seg || is_fsgs) begin
          cur_d.seg_id = is_seg ? {1'b0, in_byte[4:3]} : {2'b10, in_byte[0]};
          cur_d.seg_pre = 1'b1;
        end
        if (in_byte == 8'h66) cur_d.opsize = ~dop_q;
        if (in_byte == 8'h67) cur_d.adsize = ~dad_q;
        if (in_byte == 8'hf0) cur_d.lock = 1'b1;
        if (in_byte[7:1] == 7'b1111001) cur_d.rep = {1'b1, in_byte[0]};
      end
      if (term) begin
        out_d = cur_d;
        out_d.opcode = {state_q == ESC, in_byte};
        out_d.fault = state_q == PREFIX && is_pfx && hit_max;
        out_d.ip_next = ip_q + IP_WIDTH'(1);
      end
    end
  end
  always_comb begin
    out_valid = state_q == OUT;
    in_ready = state_q != OUT && !flush && !reset;
  end
  assign ip = ip_q;
  assign out_opcode = out_q.opcode;
  assign out_seg_id = out_q.seg_id;
  assign out_seg_pre = out_q.seg_pre;
  assign out_opsize = out_q.opsize;
  assign out_adsize = out_q.adsize;
  assign out_rep = out_q.rep;
  assign out_lock = out_q.lock;
  assign out_len = out_q.len;
  assign out_fault = out_q.fault;
  assign out_ip_start = out_q.ip_start;
  assign out_ip_next = out_q.ip_next;
endmodule

// File: tb/tb_x86_prefix_decoder.sv
// tb_x86_prefix_decoder: randomized and directed checks of the prefix decoder against a byte-list model
module tb_x86_prefix_decoder;
  localparam logic [31:0] RIP = 32'h0;
  typedef logic [7:0] bq_t[$];
  logic        clk = 0, rst = 1, dop = 0, dad = 0, fl = 0, iv = 0, ordy = 0;
  logic [31:0] fip = 0;
  logic [7:0]  ib = 0;
  logic        ir, ov, seg_pre, osz, asz, lock, fault;
  logic [31:0] ip, ips, ipn;
  logic [8:0]  opc;
  logic [2:0]  seg;
  logic [1:0]  rep;
  logic [3:0]  len;
  logic [86:0] d_rec;
  int          checks = 0, errors = 0;
  bq_t         q, s;
  logic        m_hold = 0, m_dop = 0, m_dad = 0;
  logic [31:0] m_ip = 0, m_ips = 0, saved_ip;
  logic [86:0] m_rec = 0;
  logic [7:0]  tbl [12] = '{8'h26, 8'h2e, 8'h36, 8'h3e, 8'h64, 8'h65, 8'h66, 8'h67, 8'hf0, 8'hf2, 8'hf3, 8'h0f};

  always #5 clk = ~clk;

  x86_prefix_decoder dut (
    .clock(clk), .reset(rst), .def_opsize(dop), .def_adsize(dad), .flush(fl), .flush_ip(fip),
    .in_valid(iv), .in_byte(ib), .in_ready(ir), .ip(ip), .out_valid(ov), .out_ready(ordy),
    .out_opcode(opc), .out_seg_id(seg), .out_seg_pre(seg_pre), .out_opsize(osz), .out_adsize(asz),
    .out_rep(rep), .out_lock(lock), .out_len(len), .out_fault(fault), .out_ip_start(ips), .out_ip_next(ipn)
  );

  assign d_rec = {opc, seg, seg_pre, osz, asz, rep, lock, len, fault, ips, ipn};

  task automatic chk(input string name, input logic [86:0] act, input logic [86:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_pfx(input logic [7:0] b);
    return b inside {8'h26, 8'h2e, 8'h36, 8'h3e, 8'h64, 8'h65, 8'h66, 8'h67, 8'hf0, 8'hf2, 8'hf3};
  endfunction

  function automatic bit complete(input bq_t x);
    bit esc = 0;
    foreach (x[i]) begin
      if (esc || !(is_pfx(x[i]) || x[i] == 8'h0f)) return 1;
      if (x[i] == 8'h0f) esc = 1;
    end
    return x.size() == 15;
  endfunction

  function automatic logic [86:0] decode(input bq_t x, input logic d_op, input logic d_ad,
                                         input logic [31:0] st, input logic [31:0] nx);
    logic [2:0] sg;
    logic       sp, op, ad, lk, esc, ft;
    logic [1:0] rp;
    logic [8:0] oc;
    logic [7:0] b;
    sg = 3; sp = 0; op = d_op; ad = d_ad; lk = 0; esc = 0; ft = 1; rp = 0; oc = 0;
    foreach (x[i]) begin
      b = x[i];
      if (esc) begin oc = {1'b1, b}; ft = 0; end
      else if (b inside {8'h26, 8'h2e, 8'h36, 8'h3e}) begin sg = 3'((b - 8'h26) >> 3); sp = 1; end
      else if (b inside {8'h64, 8'h65}) begin sg = 3'(b - 8'h60); sp = 1; end
      else if (b == 8'h66) op = !d_op;
      else if (b == 8'h67) ad = !d_ad;
      else if (b == 8'hf0) lk = 1;
      else if (b == 8'hf2) rp = 2'b10;
      else if (b == 8'hf3) rp = 2'b11;
      else if (b == 8'h0f) esc = 1;
      else begin oc = {1'b0, b}; ft = 0; end
    end
    if (ft) oc = {1'b0, x[x.size()-1]};
    return {oc, sg, sp, op, ad, rp, lk, 4'(x.size()), ft, st, nx};
  endfunction

  task automatic cycle(input logic v, input logic [7:0] b, input logic f, input logic [31:0] fa, input logic r);
    @(negedge clk);
    iv = v; ib = b; fl = f; fip = fa; ordy = r;
    #1;
    chk("in_ready", 87'(ir), 87'(!rst && !m_hold && !f));
    if (rst || f) begin
      m_hold = 0; q.delete(); m_ip = rst ? RIP : fa; m_ips = m_ip; m_dop = dop; m_dad = dad;
    end else if (m_hold) begin
      if (r) begin m_hold = 0; q.delete(); m_ips = m_ip; m_dop = dop; m_dad = dad; end
    end else if (v) begin
      q.push_back(b);
      m_ip++;
      if (complete(q)) begin m_hold = 1; m_rec = decode(q, m_dop, m_dad, m_ips, m_ip); end
    end
    @(posedge clk);
    #1;
    chk("ip", 87'(ip), 87'(m_ip));
    chk("out_valid", 87'(ov), 87'(m_hold));
    if (m_hold) chk("record", d_rec, m_rec);
  endtask

  task automatic send(input bq_t x);
    foreach (x[i]) cycle(1, x[i], 0, 0, 0);
  endtask

  task automatic accept();
    cycle(0, 0, 0, 0, 1);
  endtask

  initial begin
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("reset record", d_rec, 87'h0);
    chk("reset ip", 87'(ip), 87'h0);
    rst = 0;
    s = '{8'h90};
    send(s);
    chk("t1 opcode", 87'(opc), 87'h090);
    chk("t1 len", 87'(len), 87'd1);
    chk("t1 seg", 87'(seg), 87'd3);
    chk("t1 rep", 87'(rep), 87'd0);
    chk("t1 ip_next", 87'(ipn), 87'(RIP + 1));
    accept();
    s = '{8'h66, 8'h66, 8'h2e, 8'h65, 8'hf3, 8'ha5};
    send(s);
    chk("t2 opsize", 87'(osz), 87'd1);
    chk("t2 seg", 87'(seg), 87'd5);
    chk("t2 seg_pre", 87'(seg_pre), 87'd1);
    chk("t2 rep", 87'(rep), 87'd3);
    chk("t2 len", 87'(len), 87'd6);
    chk("t2 fault", 87'(fault), 87'd0);
    accept();
    s = '{8'h0f, 8'h84};
    send(s);
    chk("t3 opcode", 87'(opc), 87'h184);
    chk("t3 len", 87'(len), 87'd2);
    accept();
    s = '{8'h26, 8'h0f, 8'h05};
    send(s);
    chk("t4 opcode", 87'(opc), 87'h105);
    chk("t4 seg", 87'(seg), 87'd0);
    chk("t4 len", 87'(len), 87'd3);
    accept();
    s = {};
    repeat (15) s.push_back(8'h66);
    send(s);
    chk("t5 fault", 87'(fault), 87'd1);
    chk("t5 len", 87'(len), 87'd15);
    chk("t5 opcode", 87'(opc), 87'h066);
    saved_ip = ip;
    repeat (5) cycle(1, 8'h90, 0, 0, 0);
    chk("t5 in_ready held", 87'(ir), 87'd0);
    chk("t5 ip held", 87'(ip), 87'(saved_ip));
    accept();
    s = {};
    repeat (14) s.push_back(8'hf0);
    s.push_back(8'h90);
    send(s);
    chk("t6 fault", 87'(fault), 87'd0);
    chk("t6 len", 87'(len), 87'd15);
    chk("t6 lock", 87'(lock), 87'd1);
    accept();
    s = '{8'hf0, 8'h2e};
    send(s);
    cycle(1, 8'h90, 1, 32'd100, 0);
    s = '{8'h90};
    send(s);
    chk("t7 lock", 87'(lock), 87'd0);
    chk("t7 seg_pre", 87'(seg_pre), 87'd0);
    chk("t7 ip_start", 87'(ips), 87'd100);
    cycle(0, 0, 1, 32'd200, 0);
    chk("t7 flush drop", 87'(ov), 87'd0);
    for (int blk = 0; blk < 6; blk++) begin
      for (int n = 0; n < 500; n++) begin
        logic [7:0] b;
        dop = 1'($urandom);
        dad = 1'($urandom);
        b = ($urandom_range(99) < ((blk % 2 == 1) ? 90 : 50)) ? tbl[$urandom_range(11)] : 8'($urandom);
        cycle($urandom_range(3) != 0, b, $urandom_range(59) == 0,
              ($urandom_range(3) == 0) ? 32'hffff_fff0 + $urandom_range(15) : $urandom,
              $urandom_range(1) == 1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
